// File: rtl/gat_pkg.sv
// rtl/gat_pkg.sv - shared types and constants for the GAT layer scheduler
package gat_pkg;

    localparam int DBG_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/gat_sched_cnt.sv
// rtl/gat_sched_cnt.sv - RUN cycle counter with first-event capture and timeout compare
module gat_sched_cnt
    import gat_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2**30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             evt_i,
    output logic [DBG_W-1:0] cnt_o,
    output logic             seen_o,
    output logic             first_o,
    output logic             tmo_o
);

    logic [DBG_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;

    // Count while enabled; remember whether the tracked event has happened yet.
    always_comb begin
        cnt_d  = cnt_q;
        seen_d = seen_q;
        if (clr_i) begin
            cnt_d  = '0;
            seen_d = 1'b0;
        end else if (en_i) begin
            cnt_d = cnt_q + DBG_W'(1);
            if (evt_i) begin
                seen_d = 1'b1;
            end
        end
    end

    // Counter and seen-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign seen_o  = seen_q;
    assign first_o = en_i & ~clr_i & evt_i & ~seen_q;
    assign tmo_o   = en_i & (cnt_q == DBG_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gat_layer_sched.sv
// rtl/gat_layer_sched.sv - sequences conv layers through the shared load/compute path
module gat_layer_sched
    import gat_pkg::*;
#(
    parameter int NUM_LAYERS     = 2,
    parameter int LAYER_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    parameter int TIMEOUT_CYCLES = 2**30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               h_data_load_done,
    input  logic               h_node_info_load_done,
    input  logic               wgt_load_done,
    input  logic               conv_feat_wr,
    input  logic               conv_ready,
    output logic               load_req,
    output logic               load_clr,
    output logic [LAYER_W-1:0] gat_layer,
    output logic               conv_start,
    output logic               busy,
    output logic               gat_ready,
    output logic               err,
    output logic [DBG_W-1:0]   dbg_lat,
    output logic [DBG_W-1:0]   dbg_total
);

    sched_state_e       state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [2:0]         ld_q, ld_d;
    logic               load_clr_q, load_clr_d;
    logic               conv_start_q, conv_start_d;
    logic               load_req_q, busy_q, gat_ready_q, err_q;
    logic [DBG_W-1:0]   lat_q, lat_d;
    logic [DBG_W-1:0]   total_q, total_d;

    logic [DBG_W-1:0]   cyc;
    logic               feat_seen, feat_first, tmo;
    logic               in_run, ready_ok;
    logic [2:0]         ld_in;

    assign in_run   = (state_q == ST_RUN);
    assign ld_in    = {h_data_load_done, h_node_info_load_done, wgt_load_done};
    // A ready on the first RUN cycle is left over from the previous layer.
    assign ready_ok = in_run & conv_ready & (cyc != '0);

    gat_sched_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (~in_run),
        .en_i   (in_run),
        .evt_i  (conv_feat_wr),
        .cnt_o  (cyc),
        .seen_o (feat_seen),
        .first_o(feat_first),
        .tmo_o  (tmo)
    );

    // Next-state, loader bookkeeping and debug capture.
    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        ld_d         = ld_q;
        load_clr_d   = 1'b0;
        conv_start_d = 1'b0;
        lat_d        = lat_q;
        total_d      = total_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    layer_d    = '0;
                    ld_d       = '0;
                    load_clr_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // Loaders are still dropping their flags during the clear cycle.
                if (!load_clr_q) begin
                    ld_d = ld_q | ld_in;
                    if (&ld_d) begin
                        state_d      = ST_RUN;
                        conv_start_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (feat_first) begin
                    lat_d = cyc;
                end
                if (ready_ok) begin
                    total_d = cyc;
                    if (!feat_seen) begin
                        lat_d = cyc;
                    end
                    if (layer_q == LAYER_W'(NUM_LAYERS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_LOAD;
                        layer_d    = layer_q + LAYER_W'(1);
                        ld_d       = '0;
                        load_clr_d = 1'b1;
                    end
                end else if (tmo) begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            layer_q      <= '0;
            ld_q         <= '0;
            load_clr_q   <= 1'b0;
            conv_start_q <= 1'b0;
            load_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            gat_ready_q  <= 1'b0;
            err_q        <= 1'b0;
            lat_q        <= '0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            ld_q         <= ld_d;
            load_clr_q   <= load_clr_d;
            conv_start_q <= conv_start_d;
            load_req_q   <= (state_d == ST_LOAD);
            busy_q       <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            gat_ready_q  <= (state_d == ST_DONE);
            err_q        <= (state_d == ST_ERR);
            lat_q        <= lat_d;
            total_q      <= total_d;
        end
    end

    assign load_req   = load_req_q;
    assign load_clr   = load_clr_q;
    assign gat_layer  = layer_q;
    assign conv_start = conv_start_q;
    assign busy       = busy_q;
    assign gat_ready  = gat_ready_q;
    assign err        = err_q;
    assign dbg_lat    = lat_q;
    assign dbg_total  = total_q;

endmodule

// File: tb/tb_gat_layer_sched.sv
// tb/tb_gat_layer_sched.sv - self-checking bench for gat_layer_sched
module tb_gat_layer_sched;

    localparam int NL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic h_data_load_done = 1'b0;
    logic h_node_info_load_done = 1'b0;
    logic wgt_load_done = 1'b0;
    logic conv_feat_wr = 1'b0;
    logic conv_ready = 1'b0;

    logic        load_req, load_clr, conv_start, busy, gat_ready, err;
    logic [0:0]  gat_layer;
    logic [31:0] dbg_lat, dbg_total;

    logic        load_req_to, load_clr_to, conv_start_to, busy_to, gat_ready_to, err_to;
    logic [0:0]  gat_layer_to;
    logic [31:0] dbg_lat_to, dbg_total_to;

    int checks = 0;
    int failures = 0;
    int prev_total = 0;

    always #5 clk = ~clk;

    gat_layer_sched #(.NUM_LAYERS(NL)) dut (
        .clk(clk), .rst(rst), .start(start),
        .h_data_load_done(h_data_load_done), .h_node_info_load_done(h_node_info_load_done),
        .wgt_load_done(wgt_load_done), .conv_feat_wr(conv_feat_wr), .conv_ready(conv_ready),
        .load_req(load_req), .load_clr(load_clr), .gat_layer(gat_layer), .conv_start(conv_start),
        .busy(busy), .gat_ready(gat_ready), .err(err), .dbg_lat(dbg_lat), .dbg_total(dbg_total)
    );

    gat_layer_sched #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(50)) dut_to (
        .clk(clk), .rst(rst), .start(start),
        .h_data_load_done(h_data_load_done), .h_node_info_load_done(h_node_info_load_done),
        .wgt_load_done(wgt_load_done), .conv_feat_wr(conv_feat_wr), .conv_ready(conv_ready),
        .load_req(load_req_to), .load_clr(load_clr_to), .gat_layer(gat_layer_to), .conv_start(conv_start_to),
        .busy(busy_to), .gat_ready(gat_ready_to), .err(err_to), .dbg_lat(dbg_lat_to), .dbg_total(dbg_total_to)
    );

    typedef struct {
        int dh; int dn; int dw;
        int stale_wgt; int stale_rdy;
        int feat; int feat2; int rdy;
        int start_mid;
        int exp_lat; int exp_total;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int model_lat(input int feat, input int rdy);
        return (feat >= 0 && feat <= rdy) ? feat : rdy;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_total = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_load_req", load_req, 1);
        chk("start_busy", busy, 1);
        chk("start_ready_drop", gat_ready, 0);
        chk("start_err_drop", err, 0);
    endtask

    // Entered on the clear cycle; returns on the first RUN cycle.
    task automatic do_load(input int dh, input int dn, input int dw,
                           input int stale_wgt, input int stale_rdy, input int layer);
        int k;
        int dmax;
        dmax = dh;
        if (dn > dmax) dmax = dn;
        if (dw > dmax) dmax = dw;
        chk("load_clr_pulse", load_clr, 1);
        chk("load_layer", gat_layer, layer);
        chk("load_req_high", load_req, 1);
        k = 0;
        while (k <= dmax + 3) begin
            h_data_load_done      = (k == dh);
            h_node_info_load_done = (k == dn);
            wgt_load_done         = (k == dw) || (stale_wgt != 0 && k == 0);
            conv_ready            = (stale_rdy != 0);
            @(negedge clk);
            k++;
            if (k == 1) chk("load_clr_one_cycle", load_clr, 0);
            if (conv_start) break;
        end
        h_data_load_done = 1'b0;
        h_node_info_load_done = 1'b0;
        wgt_load_done = 1'b0;
        chk("conv_start_time", k, dmax + 1);
        chk("run_layer", gat_layer, layer);
        chk("run_load_req_low", load_req, 0);
    endtask

    // Entered on the first RUN cycle (cyc 0); returns one cycle after ready is taken.
    task automatic do_run(input int feat, input int feat2, input int rdy, input int stale_rdy,
                          input int start_mid, input int layer, input int last);
        for (int i = 0; i <= rdy; i++) begin
            conv_feat_wr = (i == feat) || (i == feat2);
            conv_ready   = (i == rdy) || (stale_rdy != 0 && i == 0);
            start        = (start_mid != 0 && i == 2);
            @(negedge clk);
            if (start_mid != 0 && i == 2) begin
                chk("mid_start_layer", gat_layer, layer);
                chk("mid_start_no_clr", load_clr, 0);
                chk("mid_start_busy", busy, 1);
            end
        end
        conv_feat_wr = 1'b0;
        start = 1'b0;
        conv_ready = (last == 0 && stale_rdy != 0);
        if (last != 0) begin
            chk("done_gat_ready", gat_ready, 1);
            chk("done_busy", busy, 0);
            chk("done_err", err, 0);
        end
    endtask

    task automatic run_pass(input vec_t v);
        do_start();
        chk("dbg_total_held", dbg_total, prev_total);
        for (int l = 0; l < NL; l++) begin
            do_load(v.dh, v.dn, v.dw, v.stale_wgt, v.stale_rdy, l);
            do_run(v.feat, v.feat2, v.rdy, v.stale_rdy, v.start_mid, l, (l == NL - 1) ? 1 : 0);
            chk("dbg_lat", dbg_lat, v.exp_lat);
            chk("dbg_total", dbg_total, v.exp_total);
        end
        prev_total = v.exp_total;
    endtask

    task automatic timeout_test();
        int i;
        apply_reset();
        do_start();
        do_load(1, 1, 1, 0, 0, 0);
        do_run(-1, -1, 5, 0, 0, 0, 0);
        do_load(1, 1, 1, 0, 0, 1);
        i = 0;
        while (!err_to && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk("timeout_cycle", i, 50);
        chk("timeout_layer_held", gat_layer_to, 1);
        chk("timeout_busy", busy_to, 0);
        chk("timeout_main_no_err", err, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared_by_start", err_to, 0);
        chk("err_restart_clr", load_clr_to, 1);
        chk("err_restart_layer", gat_layer_to, 0);
        chk("main_run_ignores_start", load_clr, 0);
        chk("main_run_layer_kept", gat_layer, 1);
        apply_reset();
    endtask

    task automatic reset_mid_run_test();
        int n;
        apply_reset();
        do_start();
        do_load(2, 2, 2, 0, 0, 0);
        do_run(-1, -1, 5, 0, 0, 0, 0);
        do_load(2, 2, 2, 0, 0, 1);
        do_run(3, -1, 3, 0, 0, 1, 1);
        do_start();
        do_load(2, 2, 2, 0, 0, 0);
        do_run(-1, -1, 5, 0, 0, 0, 0);
        do_load(2, 2, 2, 0, 0, 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_load_req", load_req, 0);
        chk("arst_load_clr", load_clr, 0);
        chk("arst_layer", gat_layer, 0);
        chk("arst_conv_start", conv_start, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", gat_ready, 0);
        chk("arst_err", err, 0);
        chk("arst_dbg_lat", dbg_lat, 0);
        chk("arst_dbg_total", dbg_total, 0);
        #1 rst = 1'b0;
        prev_total = 0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            h_data_load_done = 1'b1;
            h_node_info_load_done = 1'b1;
            wgt_load_done = 1'b1;
            conv_ready = 1'b1;
            @(negedge clk);
            n += (conv_start || load_clr || busy) ? 1 : 0;
        end
        h_data_load_done = 1'b0;
        h_node_info_load_done = 1'b0;
        wgt_load_done = 1'b0;
        conv_ready = 1'b0;
        chk("no_activity_after_rst", n, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t rv;

        tbl[0] = '{5, 5, 5, 0, 0, 40, -1, 100, 0, 40, 100};
        tbl[1] = '{6, 3, 1, 0, 0, 12, 30, 50, 0, 12, 50};
        tbl[2] = '{1, 2, 5, 1, 0, 3, -1, 9, 0, 3, 9};
        tbl[3] = '{2, 2, 2, 0, 1, -1, -1, 1, 0, 1, 1};
        tbl[4] = '{3, 3, 3, 0, 0, 7, -1, 7, 0, 7, 7};
        tbl[5] = '{1, 1, 1, 0, 0, 0, 4, 5, 0, 0, 5};
        tbl[6] = '{2, 1, 3, 0, 0, -1, -1, 20, 0, 20, 20};
        tbl[7] = '{4, 2, 3, 0, 0, 10, -1, 25, 1, 10, 25};

        @(negedge clk);
        chk("rst_load_req", load_req, 0);
        chk("rst_load_clr", load_clr, 0);
        chk("rst_layer", gat_layer, 0);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", gat_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_dbg_lat", dbg_lat, 0);
        chk("rst_dbg_total", dbg_total, 0);
        rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            run_pass(tbl[t]);
        end

        for (int r = 0; r < 6; r++) begin
            rv.dh = int'($urandom_range(1, 6));
            rv.dn = int'($urandom_range(1, 6));
            rv.dw = int'($urandom_range(1, 6));
            rv.stale_wgt = int'($urandom_range(0, 1));
            rv.stale_rdy = int'($urandom_range(0, 1));
            rv.rdy = int'($urandom_range(3, 60));
            rv.feat = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70));
            rv.feat2 = (rv.feat < 0) ? -1 : rv.feat + int'($urandom_range(1, 10));
            rv.start_mid = int'($urandom_range(0, 1));
            rv.exp_lat = model_lat(rv.feat, rv.rdy);
            rv.exp_total = rv.rdy;
            run_pass(rv);
        end

        timeout_test();
        reset_mid_run_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
